// File: rtl/uart_tx.sv
// UART transmitter: 8N2 framing, LSB first, idle-high line.
// Bytes enter through a valid/ready handshake into a small circular FIFO.
// Frames go out back-to-back with no idle gap while the FIFO holds data.
module uart_tx #(
  parameter int CLKS_PER_BIT = 53,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST  = IDX_W'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] FULL_COUNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [FCNT_W-1:0]    count;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 stop_end;

  // tx_ready and busy come from registered state only, never from tx_valid
  assign fifo_empty = (count == '0);
  assign tx_ready   = (count != FULL_COUNT);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (bit_cnt == BIT_LAST);
  assign stop_end   = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
  assign shift_next = shift >> 1;

  // A byte leaves the FIFO when the line is idle or the last stop bit ends
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && ((state == IDLE) || stop_end)) begin
      pop = 1'b1;
    end
  end

  // FIFO storage; contents need no reset because count marks them invalid
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count steady
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; tx only changes at bit boundaries so the line is glitch-free
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shift   <= shift_next;
              tx      <= shift_next[0];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (pop) begin
                shift <= mem[rd_ptr];
                tx    <= 1'b0;
                state <= START;
              end else begin
                tx    <= 1'b1;
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a mid-bit line decoder pops a scoreboard
// of accepted bytes, plus directed checks of timing, back-pressure and abort.
module tb_uart_tx;

  localparam int CPB        = 53;
  localparam int FRAME      = 11 * CPB;
  localparam int NUM_RANDOM = 64;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int         vectors    = 0;
  int         miscompares = 0;
  int         cycle      = 0;
  int         acceptCycle;
  int         decoded    = 0;
  int         tracked    = 0;
  bit         decEnable  = 1'b0;
  logic [7:0] expQ[$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  // 10-unit clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Free-running edge counter used to time events
  always @(posedge Clk) cycle <= cycle + 1;

  // Hard stop in case something hangs
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cycle);
    end
  endtask

  // Offer one byte; called #1 after a rising edge and returns #1 after one
  task automatic applyStimulus(input logic [7:0] b, input bit track, input int maxWait);
    int waited;
    waited   = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && waited < maxWait) begin
      @(posedge Clk);
      #1;
      waited++;
    end
    if (!tx_ready) begin
      checkOutput("acceptTimeout", 32'(tx_ready), 32'd1);
    end else begin
      @(posedge Clk);
      #1;
      acceptCycle = cycle;
      if (track) begin
        expQ.push_back(b);
        tracked++;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge Clk);
      #1;
      n++;
    end
    checkOutput("idleTimeout", 32'(busy), 32'd0);
  endtask

  // Line decoder: detects a start edge, samples each bit at its centre
  initial begin
    logic [7:0] rx;
    logic [7:0] exp;
    forever begin
      @(negedge Clk);
      if (decEnable && Rst_n === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge Clk);
        checkOutput("startBit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge Clk);
          rx[i] = tx;
        end
        for (int s = 0; s < 2; s++) begin
          repeat (CPB) @(negedge Clk);
          checkOutput($sformatf("stopBit%0d", s), 32'(tx), 32'd1);
        end
        if (expQ.size() == 0) begin
          checkOutput("sbUnderflow", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          exp = expQ.pop_front();
          checkOutput("rxByte", 32'(rx), 32'(exp));
        end
        decoded++;
      end
    end
  end

  initial begin
    int         lowSeen;
    int         firstAccept;
    int         endCycle;
    int         n;
    int         waitLen;
    logic [7:0] pat;
    logic [7:0] burst [4];
    logic [7:0] fill [5];
    logic       expLevel;

    burst = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    fill  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

    Rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rstTx", 32'(tx), 32'd1);
    checkOutput("rstReady", 32'(tx_ready), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    @(negedge Clk);
    Rst_n     = 1'b1;
    decEnable = 1'b1;

    // Quiet line after reset release
    lowSeen = 0;
    repeat (100) begin
      @(negedge Clk);
      if (tx !== 1'b1) lowSeen++;
    end
    checkOutput("idleLine", 32'(lowSeen), 32'd0);
    @(posedge Clk);
    #1;

    // Single byte 0xA5: latency, per-bit levels, busy duration
    pat = 8'hA5;
    applyStimulus(pat, 1'b1, 10);
    firstAccept = acceptCycle;
    checkOutput("preFallTx", 32'(tx), 32'd1);
    @(posedge Clk);
    #1;
    checkOutput("fallTx", 32'(tx), 32'd0);
    for (int k = 0; k < 11; k++) begin
      waitLen = (k == 0) ? CPB / 2 : CPB;
      repeat (waitLen) @(posedge Clk);
      #1;
      if (k == 0) expLevel = 1'b0;
      else if (k <= 8) expLevel = pat[k-1];
      else expLevel = 1'b1;
      checkOutput($sformatf("a5Level%0d", k), 32'(tx), 32'(expLevel));
    end
    repeat (firstAccept + FRAME - cycle) @(posedge Clk);
    #1;
    checkOutput("busyLastCycle", 32'(busy), 32'd1);
    @(posedge Clk);
    #1;
    checkOutput("busyDrop", 32'(busy), 32'd0);

    // Burst of four: frames must be contiguous
    repeat (5) @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(burst[i], 1'b1, 10);
      if (i == 0) firstAccept = acceptCycle;
    end
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    endCycle = cycle;
    checkOutput("burstSpan", 32'(endCycle - (firstAccept + 1)), 32'(4 * FRAME));
    @(posedge Clk);
    #1;

    // Fill the FIFO, then hold 0x55 against back-pressure
    for (int i = 0; i < 5; i++) begin
      applyStimulus(fill[i], 1'b1, 10);
      if (i == 0) firstAccept = acceptCycle;
    end
    checkOutput("fullReady", 32'(tx_ready), 32'd0);
    checkOutput("fullBusy", 32'(busy), 32'd1);
    applyStimulus(8'h55, 1'b1, 2 * FRAME);
    checkOutput("ovfAccept", 32'(acceptCycle), 32'(firstAccept + FRAME + 2));
    waitIdle(6 * FRAME + 100);
    repeat (5) @(posedge Clk);
    #1;

    // Abort mid-frame: reset during data bit 3 of 0xC3 with a byte queued
    decEnable = 1'b0;
    applyStimulus(8'hC3, 1'b0, 10);
    applyStimulus(8'h5A, 1'b0, 10);
    repeat (4 * CPB + 20) @(posedge Clk);
    #1;
    checkOutput("abortBit3", 32'(tx), 32'd0);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("abortTx", 32'(tx), 32'd1);
    checkOutput("abortReady", 32'(tx_ready), 32'd1);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    lowSeen = 0;
    repeat (2 * FRAME) begin
      @(negedge Clk);
      if (tx !== 1'b1) lowSeen++;
    end
    checkOutput("abortSilent", 32'(lowSeen), 32'd0);
    checkOutput("abortIdleBusy", 32'(busy), 32'd0);
    decEnable = 1'b1;
    @(posedge Clk);
    #1;

    // Random loopback with random gaps
    for (int i = 0; i < NUM_RANDOM; i++) begin
      if ($urandom_range(0, 7) == 0) waitLen = $urandom_range(100, 700);
      else waitLen = $urandom_range(0, 3);
      repeat (waitLen) @(posedge Clk);
      #1;
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, 2 * FRAME);
    end
    waitIdle(6 * FRAME + 100);
    repeat (10) @(posedge Clk);
    #1;
    checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("decodedCount", 32'(decoded), 32'(tracked));

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
